// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers and entry layout for the AXI-Stream packet FIFO.
// Each entry is packed as {TDATA, TSTRB, TUSER, TLAST} with TLAST at bit 0.
package axis_fifo_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int entry_width(input int data_w, input int user_w);
      return data_w + data_w / 8 + user_w + 1;
   endfunction

   localparam int LAST_OFS = 0;
   localparam int USER_OFS = 1;

   function automatic int strb_ofs(input int user_w);
      return USER_OFS + user_w;
   endfunction

   function automatic int data_ofs(input int data_w, input int user_w);
      return USER_OFS + user_w + data_w / 8;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, so the
// read port can present the head entry in the same cycle (first-word fall-through).
module axis_fifo_ram
   import axis_fifo_pkg::*;
#(
   parameter int WIDTH = 38,
   parameter int DEPTH = 16,
   localparam int AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage has no reset; validity is tracked by the pointers and fill count.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with FWFT output, exact full/empty, almost
// flags, packet counting and an optional store-and-forward gate on TLAST.
module axis_pkt_fifo
   import axis_fifo_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH  = 32,
   parameter int C_S_AXIS_TUSER_WIDTH  = 1,
   parameter int C_FIFO_DEPTH          = 16,
   parameter int C_PACKET_MODE         = 0,
   parameter int C_ALMOST_FULL_THRESH  = 12,
   parameter int C_ALMOST_EMPTY_THRESH = 4,
   localparam int PW = clog2(C_FIFO_DEPTH),
   localparam int CW = PW + 1,
   localparam int SW = C_S_AXIS_TDATA_WIDTH / 8
) (
   input  logic                            S_AXIS_ACLK,
   input  logic                            S_AXIS_ARESET,
   input  logic                            S_AXIS_TVALID,
   output logic                            S_AXIS_TREADY,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [SW-1:0]                   S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0] S_AXIS_TUSER,
   input  logic                            S_AXIS_TLAST,
   output logic                            M_AXIS_TVALID,
   input  logic                            M_AXIS_TREADY,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic [SW-1:0]                   M_AXIS_TSTRB,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
   output logic                            M_AXIS_TLAST,
   output logic [CW-1:0]                   fill_level,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic [CW-1:0]                   pkt_count
);

   localparam int EW     = entry_width(C_S_AXIS_TDATA_WIDTH, C_S_AXIS_TUSER_WIDTH);
   localparam int STRB_O = strb_ofs(C_S_AXIS_TUSER_WIDTH);
   localparam int DATA_O = data_ofs(C_S_AXIS_TDATA_WIDTH, C_S_AXIS_TUSER_WIDTH);
   localparam logic [CW-1:0] FULL_LVL = CW'(C_FIFO_DEPTH);

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] fill_q, fill_d, pkt_q, pkt_d;
   logic          tready_q, af_q, ae_q;
   logic          wr, rd, pkt_gate;
   logic [EW-1:0] wr_entry, rd_entry;

   assign wr = S_AXIS_TVALID && tready_q;
   assign rd = M_AXIS_TVALID && M_AXIS_TREADY;

   // Full-override lets a packet longer than the depth drain instead of deadlocking.
   assign pkt_gate      = (C_PACKET_MODE == 0) || (pkt_q != '0) || (fill_q == FULL_LVL);
   assign M_AXIS_TVALID = (fill_q != '0) && pkt_gate;

   assign wr_entry = {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};

   axis_fifo_ram #(
      .WIDTH (EW),
      .DEPTH (C_FIFO_DEPTH)
   ) u_ram (
      .clk     (S_AXIS_ACLK),
      .we_i    (wr),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   assign M_AXIS_TDATA = rd_entry[DATA_O +: C_S_AXIS_TDATA_WIDTH];
   assign M_AXIS_TSTRB = rd_entry[STRB_O +: SW];
   assign M_AXIS_TUSER = rd_entry[USER_OFS +: C_S_AXIS_TUSER_WIDTH];
   assign M_AXIS_TLAST = rd_entry[LAST_OFS];

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      fill_d = fill_q;
      pkt_d  = pkt_q;
      case ({wr, rd})
         2'b10:   fill_d = fill_q + CW'(1);
         2'b01:   fill_d = fill_q - CW'(1);
         default: fill_d = fill_q;
      endcase
      case ({wr && S_AXIS_TLAST, rd && M_AXIS_TLAST})
         2'b10:   pkt_d = pkt_q + CW'(1);
         2'b01:   pkt_d = pkt_q - CW'(1);
         default: pkt_d = pkt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         pkt_q    <= '0;
         tready_q <= 1'b0;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd) rd_ptr_q <= rd_ptr_q + PW'(1);
         fill_q   <= fill_d;
         pkt_q    <= pkt_d;
         tready_q <= (fill_d < FULL_LVL);
         af_q     <= (fill_d >= CW'(C_ALMOST_FULL_THRESH));
         ae_q     <= (fill_d <= CW'(C_ALMOST_EMPTY_THRESH));
      end
   end

   assign S_AXIS_TREADY = tready_q;
   assign fill_level    = fill_q;
   assign pkt_count     = pkt_q;
   assign almost_full   = af_q;
   assign almost_empty  = ae_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: cut-through and store-and-forward instances
// share one stimulus; a queue scoreboard models contents, counts and flags.
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        u;
      logic        l;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_tvalid = 1'b0;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tstrb = '0;
   logic        s_tuser = 1'b0;
   logic        s_tlast = 1'b0;
   logic        m_tready = 1'b0;

   logic        o_tready [2];
   logic        o_tvalid [2];
   logic [31:0] o_tdata  [2];
   logic [3:0]  o_tstrb  [2];
   logic        o_tuser  [2];
   logic        o_tlast  [2];
   logic [4:0]  o_fill   [2];
   logic [4:0]  o_pkt    [2];
   logic        o_af     [2];
   logic        o_ae     [2];

   int   tests = 0;
   int   fails = 0;
   int   act = 0;
   int   mpkt = 0;
   int   popped = 0;
   ent_t sb[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axis_pkt_fifo #(.C_PACKET_MODE(g)) dut (
         .S_AXIS_ACLK   (clk),
         .S_AXIS_ARESET (rst),
         .S_AXIS_TVALID (s_tvalid),
         .S_AXIS_TREADY (o_tready[g]),
         .S_AXIS_TDATA  (s_tdata),
         .S_AXIS_TSTRB  (s_tstrb),
         .S_AXIS_TUSER  (s_tuser),
         .S_AXIS_TLAST  (s_tlast),
         .M_AXIS_TVALID (o_tvalid[g]),
         .M_AXIS_TREADY (m_tready),
         .M_AXIS_TDATA  (o_tdata[g]),
         .M_AXIS_TSTRB  (o_tstrb[g]),
         .M_AXIS_TUSER  (o_tuser[g]),
         .M_AXIS_TLAST  (o_tlast[g]),
         .fill_level    (o_fill[g]),
         .almost_full   (o_af[g]),
         .almost_empty  (o_ae[g]),
         .pkt_count     (o_pkt[g])
      );
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: account handshakes against the scoreboard, then check state after the edge.
   task automatic step(output bit w, output bit r);
      ent_t e;
      int   pre;
      bit   exp_v;
      pre = sb.size();
      w = !rst && s_tvalid && o_tready[act];
      r = !rst && o_tvalid[act] && m_tready;
      if (r) begin
         check("rd_nonempty", pre != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            popped++;
            check("out_data", o_tdata[act], e.d);
            check("out_strb", o_tstrb[act], e.s);
            check("out_user", o_tuser[act], e.u);
            check("out_last", o_tlast[act], e.l);
            if (e.l) mpkt--;
         end
      end
      if (w) begin
         check("wr_not_full", pre < DEPTH, 1);
         sb.push_back('{d: s_tdata, s: s_tstrb, u: s_tuser, l: s_tlast});
         if (s_tlast) mpkt++;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
         mpkt = 0;
      end
      exp_v = (sb.size() != 0) && (act == 0 || mpkt != 0 || sb.size() == DEPTH);
      check("fill_level", o_fill[act], sb.size());
      check("pkt_count", o_pkt[act], mpkt);
      check("s_tready", o_tready[act], !rst && sb.size() < DEPTH);
      check("almost_full", o_af[act], sb.size() >= 12);
      check("almost_empty", o_ae[act], sb.size() <= 4);
      check("m_tvalid", o_tvalid[act], exp_v);
   endtask

   task automatic put(input logic [31:0] d, input logic [3:0] s, input logic u, input logic l);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tstrb  = s;
      s_tuser  = u;
      s_tlast  = l;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] s, input logic u, input logic l);
      bit w, r;
      int n;
      n = 0;
      put(d, s, u, l);
      do begin
         step(w, r);
         n++;
      end while (!w && n < 300);
      if (!w) check("send_timeout", w, 1);
   endtask

   task automatic drain();
      bit w, r;
      int n;
      n = 0;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      while (sb.size() != 0 && n < 300) begin
         step(w, r);
         n++;
      end
      check("drained_fill", o_fill[act], 0);
   endtask

   initial begin
      bit w, r;
      int base;

      // 1: reset then idle
      act = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(w, r);
         check("t1_rst_tready", o_tready[0], 0);
      end
      check("t1_tvalid", o_tvalid[0], 0);
      check("t1_ae", o_ae[0], 1);
      rst = 1'b0;
      check("t1_tready_at_release", o_tready[0], 0);
      step(w, r);
      check("t1_tready_after", o_tready[0], 1);

      // 2: fill to full with no reads
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(32'(i), 4'hF, 1'b0, 1'b0);
         if (i == 10) check("t2_af_at11", o_af[0], 0);
         if (i == 11) check("t2_af_at12", o_af[0], 1);
      end
      check("t2_full", o_fill[0], 16);
      check("t2_tready_low", o_tready[0], 0);
      put(32'h10, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(w, r);
         check("t2_held", w, 0);
      end

      // 3: single read while full; upstream held off in that cycle
      m_tready = 1'b1;
      check("t3_head", o_tdata[0], 32'h0);
      step(w, r);
      check("t3_no_wr", w, 0);
      check("t3_rd", r, 1);
      m_tready = 1'b0;
      check("t3_fill15", o_fill[0], 15);
      check("t3_tready", o_tready[0], 1);
      step(w, r);
      check("t3_wr10", w, 1);
      drain();

      // 4: streaming with pointer wrap
      m_tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(32'h1000 + 32'(i * 7), 4'(i) ^ 4'hA, (i % 8) == 0, (i % 10) == 9);
         check("t4_fill1", o_fill[0], 1);
      end
      drain();

      // 5: store-and-forward, 5-beat packet
      act = 1;
      rst = 1'b1;
      s_tvalid = 1'b0;
      step(w, r);
      step(w, r);
      rst = 1'b0;
      step(w, r);
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h50 + 32'(i), 4'hF, i == 0, 1'b0);
      check("t5_hold_valid", o_tvalid[1], 0);
      check("t5_pkt0", o_pkt[1], 0);
      send(32'h54, 4'h3, 1'b0, 1'b1);
      check("t5_valid", o_tvalid[1], 1);
      check("t5_pkt1", o_pkt[1], 1);
      drain();
      check("t5_pkt_end", o_pkt[1], 0);

      // 6: packet longer than the depth must still flow
      base = popped;
      m_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(32'h600 + 32'(i), 4'(i), i == 0, i == 19);
         if (i == 14) check("t6_gate_closed", o_tvalid[1], 0);
         if (i == 15) begin
            check("t6_full_valid", o_tvalid[1], 1);
            check("t6_full_fill", o_fill[1], 16);
         end
      end
      drain();
      check("t6_delivered", popped - base, 20);

      // 6b: reset mid-packet discards partial contents
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h700 + 32'(i), 4'hF, 1'b0, 1'b0);
      s_tvalid = 1'b0;
      rst = 1'b1;
      step(w, r);
      rst = 1'b0;
      check("t6_rst_fill", o_fill[1], 0);
      check("t6_rst_pkt", o_pkt[1], 0);
      check("t6_rst_valid", o_tvalid[1], 0);
      step(w, r);
      check("t6_rst_tready", o_tready[1], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
